// File: rtl/schedule_issuer_if.sv
// DRAM command bus between the schedule issuer and the PHY.
`ifndef SCHEDULE_ISSUER_DEFS
`define SCHEDULE_ISSUER_DEFS
`define CYCLE_WIDTH 8
`define BANK_GROUP_WIDTH 2
`define BANK_WIDTH 2
`define ROW_WIDTH 16
`define COLUMN_WIDTH 10
`define REQUEST_ID_WIDTH 8
`define CMD_PRE 3'd1
`define CMD_ACT 3'd2
`define CMD_RD 3'd3
`endif

// A command transfers on a clock edge where dram_cmd_valid and dram_cmd_ready are
// both 1; while valid=1 and ready=0 the master holds every field stable. valid=0
// marks a bubble slot, which needs no ready and is never held.
interface schedule_issuer_if;
    logic                           dram_cmd_valid;
    logic                           dram_cmd_ready;
    logic [2:0]                     dram_cmd_type;
    logic [`BANK_GROUP_WIDTH-1:0]   dram_bank_group;
    logic [`BANK_WIDTH-1:0]         dram_bank;
    logic [`ROW_WIDTH-1:0]          dram_row;
    logic [`COLUMN_WIDTH-1:0]       dram_column;
    logic [`REQUEST_ID_WIDTH-1:0]   dram_request_id;
    logic [`CYCLE_WIDTH-1:0]        dram_cmd_slot;

    modport master (
        output dram_cmd_valid, dram_cmd_type, dram_bank_group, dram_bank,
               dram_row, dram_column, dram_request_id, dram_cmd_slot,
        input  dram_cmd_ready
    );

    modport slave (
        input  dram_cmd_valid, dram_cmd_type, dram_bank_group, dram_bank,
               dram_row, dram_column, dram_request_id, dram_cmd_slot,
        output dram_cmd_ready
    );
endinterface

// File: rtl/schedule_issuer.sv
// Walks the generated schedule table slot by slot, prefetching through a small FIFO
// and presenting one command (or bubble) per slot on the DRAM command bus.
`ifndef SCHEDULE_ISSUER_DEFS
`define SCHEDULE_ISSUER_DEFS
`define CYCLE_WIDTH 8
`define BANK_GROUP_WIDTH 2
`define BANK_WIDTH 2
`define ROW_WIDTH 16
`define COLUMN_WIDTH 10
`define REQUEST_ID_WIDTH 8
`define CMD_PRE 3'd1
`define CMD_ACT 3'd2
`define CMD_RD 3'd3
`endif

module schedule_issuer #(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [`CYCLE_WIDTH-1:0]       sched_len,
    output logic                          busy,
    output logic                          done,
    output logic                          sched_rd_en,
    output logic [`CYCLE_WIDTH-1:0]       sched_rd_addr,
    input  logic                          sched_rd_valid,
    input  logic [2:0]                    sched_rd_cmd_type,
    input  logic [`BANK_GROUP_WIDTH-1:0]  sched_rd_bank_group,
    input  logic [`BANK_WIDTH-1:0]        sched_rd_bank,
    input  logic [`ROW_WIDTH-1:0]         sched_rd_row,
    input  logic [`COLUMN_WIDTH-1:0]      sched_rd_column,
    input  logic [`REQUEST_ID_WIDTH-1:0]  sched_rd_request_id,
    schedule_issuer_if.master             dram,
    output logic [`REQUEST_ID_WIDTH:0]    rd_issued_count,
    output logic [15:0]                   stall_cycles,
    output logic [1:0]                    dbg_state
);
    localparam int CW = `CYCLE_WIDTH;
    localparam int IW = `REQUEST_ID_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic                          valid;
        logic [2:0]                    cmd;
        logic [`BANK_GROUP_WIDTH-1:0]  bg;
        logic [`BANK_WIDTH-1:0]        bank;
        logic [`ROW_WIDTH-1:0]         row;
        logic [`COLUMN_WIDTH-1:0]      col;
        logic [`REQUEST_ID_WIDTH-1:0]  id;
    } entry_t;

    state_t                 state;
    logic [CW-1:0]          len_q;
    logic [CW-1:0]          cons_cnt;
    logic [CW:0]            pf_ptr;
    logic [RD_LATENCY-1:0]  inflight;
    entry_t                 fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [NW-1:0]          fifo_count;
    logic                   out_full;
    entry_t                 rd_entry;
    entry_t                 head;
    logic                   accept;
    logic                   out_free;
    logic                   fifo_wr;
    logic                   load;
    logic                   issue;
    logic [OW-1:0]          infl_n;
    logic [OW-1:0]          occ;

    assign rd_entry  = {sched_rd_valid, sched_rd_cmd_type, sched_rd_bank_group, sched_rd_bank,
                        sched_rd_row, sched_rd_column, sched_rd_request_id};
    assign head      = fifo_mem[rd_ptr];
    assign dbg_state = state;
    assign accept    = dram.dram_cmd_valid & dram.dram_cmd_ready;
    assign out_free  = !out_full || !dram.dram_cmd_valid || accept;
    assign fifo_wr   = inflight[RD_LATENCY-1];
    assign load      = (state == RUN) && out_free && (fifo_count != '0);

    // Occupancy counts reads still in flight so returned data always has a FIFO entry.
    always_comb begin
        infl_n = '0;
        for (int i = 0; i < RD_LATENCY; i++) infl_n = infl_n + OW'(inflight[i]);
        occ   = OW'(fifo_count) + infl_n - OW'(load);
        issue = (state == RUN) && (pf_ptr < {1'b0, len_q}) && (occ < OW'(FIFO_DEPTH));
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= rd_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            sched_rd_en          <= 1'b0;
            sched_rd_addr        <= '0;
            len_q                <= '0;
            cons_cnt             <= '0;
            pf_ptr               <= '0;
            inflight             <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fifo_count           <= '0;
            out_full             <= 1'b0;
            dram.dram_cmd_valid  <= 1'b0;
            dram.dram_cmd_type   <= '0;
            dram.dram_bank_group <= '0;
            dram.dram_bank       <= '0;
            dram.dram_row        <= '0;
            dram.dram_column     <= '0;
            dram.dram_request_id <= '0;
            dram.dram_cmd_slot   <= '0;
            rd_issued_count      <= '0;
            stall_cycles         <= '0;
        end else begin
            if (accept && dram.dram_cmd_type == `CMD_RD)
                rd_issued_count <= rd_issued_count + (IW + 1)'(1);
            if (dram.dram_cmd_valid && !dram.dram_cmd_ready && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;

            done        <= 1'b0;
            sched_rd_en <= issue;
            inflight    <= (inflight << 1) | RD_LATENCY'(issue);
            if (issue) begin
                sched_rd_addr <= pf_ptr[CW-1:0];
                pf_ptr        <= pf_ptr + (CW + 1)'(1);
            end
            if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (load) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + NW'(fifo_wr) - NW'(load);

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        len_q           <= sched_len;
                        cons_cnt        <= '0;
                        rd_issued_count <= '0;
                        stall_cycles    <= '0;
                        if (sched_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= RUN;
                            busy          <= 1'b1;
                            sched_rd_en   <= 1'b1;
                            sched_rd_addr <= '0;
                            pf_ptr        <= (CW + 1)'(1);
                            inflight      <= RD_LATENCY'(1);
                        end
                    end
                end
                RUN: begin
                    if (out_free) begin
                        if (fifo_count != '0) begin
                            out_full             <= 1'b1;
                            dram.dram_cmd_valid  <= head.valid;
                            dram.dram_cmd_type   <= head.cmd;
                            dram.dram_bank_group <= head.bg;
                            dram.dram_bank       <= head.bank;
                            dram.dram_row        <= head.row;
                            dram.dram_column     <= head.col;
                            dram.dram_request_id <= head.id;
                            dram.dram_cmd_slot   <= cons_cnt;
                            cons_cnt             <= cons_cnt + CW'(1);
                            if (cons_cnt == len_q - CW'(1)) state <= FLUSH;
                        end else begin
                            out_full            <= 1'b0;
                            dram.dram_cmd_valid <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        out_full            <= 1'b0;
                        dram.dram_cmd_valid <= 1'b0;
                        state               <= DONE;
                        done                <= 1'b1;
                        busy                <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Abort overrides everything above except the accept/stall accounting.
            if (state != IDLE && abort) begin
                state               <= IDLE;
                busy                <= 1'b0;
                done                <= 1'b0;
                sched_rd_en         <= 1'b0;
                pf_ptr              <= '0;
                inflight            <= '0;
                wr_ptr              <= '0;
                rd_ptr              <= '0;
                fifo_count          <= '0;
                out_full            <= 1'b0;
                dram.dram_cmd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/schedule_issuer.md
Name: schedule_issuer

Overview:
Consumer end of the schedule memory. The schedule generator fills a cycle-indexed table of PRE/ACT/RD commands; this block walks that table slot by slot once generation completes. It drives one command per slot onto the DRAM command bus and preserves the relative slot spacing under bus backpressure. It also reports read-issue statistics and completion back to the scheduler top.

Parameters:
RD_LATENCY, 2, schedule-memory read latency in clocks, from the edge that registers sched_rd_addr to the edge at which sched_rd_* data is valid.
FIFO_DEPTH, 4, prefetch buffer entries; must be at least RD_LATENCY+2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  begin issuing; sampled only in IDLE
abort  in  1  cancel the current run
sched_len  in  `CYCLE_WIDTH  number of slots to walk; latched on start
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
sched_rd_en  out  1  schedule memory read strobe
sched_rd_addr  out  `CYCLE_WIDTH  slot index being read
sched_rd_valid  in  1  slot holds a command (0 means empty slot)
sched_rd_cmd_type  in  3  `CMD_PRE / `CMD_ACT / `CMD_RD
sched_rd_bank_group  in  `BANK_GROUP_WIDTH  bank group
sched_rd_bank  in  `BANK_WIDTH  bank
sched_rd_row  in  `ROW_WIDTH  row
sched_rd_column  in  `COLUMN_WIDTH  column
sched_rd_request_id  in  `REQUEST_ID_WIDTH  request id
dram_cmd_valid  out  1  command present
dram_cmd_ready  in  1  PHY accepts the command
dram_cmd_type, dram_bank_group, dram_bank, dram_row, dram_column, dram_request_id  out  widths as matching sched_rd_*  command fields
dram_cmd_slot  out  `CYCLE_WIDTH  slot index of the presented command or bubble
rd_issued_count  out  `REQUEST_ID_WIDTH+1  RD commands accepted this run
stall_cycles  out  16  cycles with valid=1 and ready=0; saturates at 16'hFFFF

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0, FIFO empty, prefetch pointer 0, counters 0. Any in-flight read data is discarded.
- FSM states: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
- IDLE: on start=1, latch sched_len and clear rd_issued_count and stall_cycles.
  - If sched_len=0, go to DONE.
  - Otherwise go to RUN and register sched_rd_en=1, sched_rd_addr=0.
  - busy=1 from the following cycle.
- RUN prefetch: issue one read per cycle while prefetch pointer < latched length and (FIFO count + reads in flight) < FIFO_DEPTH. Returned data is written into the FIFO exactly RD_LATENCY cycles later; the FIFO never overflows.
- Output register: loaded from the FIFO head whenever it is empty, or holds a bubble, or holds a command being accepted (valid&ready). Each load consumes exactly one slot.
  - Empty slot: dram_cmd_valid=0 for one cycle (bubble). A bubble needs no ready.
  - Occupied slot: dram_cmd_valid=1, held stable with all fields until ready=1.
- Slot timing: slot 0 appears on the bus exactly RD_LATENCY+1 edges after the edge that samples start. With ready held at 1, slot k appears k cycles after slot 0. A stall delays all later slots equally; the relative spacing from the generator is preserved.
- rd_issued_count increments on each accepted `CMD_RD.
- End of run: when the last slot is consumed, go to FLUSH. Leave FLUSH once the output register is empty or accepted, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, dram_cmd_valid=0, FIFO flushed, busy=0.
  - No done pulse.
  - Late read returns are ignored.
  - abort has priority over a simultaneous accept; that accept is still counted.
- start while busy is ignored.
- start and abort in the same IDLE cycle: abort wins and no run starts.
- sched_rd_addr never exceeds latched length-1.
- Counter widths are fixed; no wrap beyond the stated saturation.

Test Plan:
1. Slots 0:ACT(bg0,b0,row5), 1:empty, 2:empty, 3:RD(col 8, req 3), len=4, ready=1 -> ACT at start+RD_LATENCY+1, RD exactly 3 cycles later, done 1 cycle after the RD is accepted, rd_issued_count=1.
2. Same schedule, ready=0 for 5 cycles while ACT is presented -> ACT fields held stable for those cycles, RD still 3 cycles after ACT acceptance, stall_cycles=5.
3. len=0 -> done pulses within 2 cycles of start, sched_rd_en never asserted, busy=0 afterwards.
4. 16 back-to-back RD slots, ready toggling 1/0 -> all 16 issued in order with req ids 0..15, FIFO never overflows, rd_issued_count=16.
5. abort asserted mid-run at slot 6 of 12 -> IDLE next cycle, dram_cmd_valid=0, no done pulse. A new start replays from slot 0 with counters cleared.
6. rst_n=0 for one cycle mid-run -> all outputs 0 on the next cycle; the bus is clean afterwards even though a read return is still pending.
